// File: rtl/sound_pkg.sv
// Shared constants and helpers for the sound command FIFO.
package sound_pkg;

    localparam int unsigned DW_DEF        = 8;
    localparam int unsigned EMPTY_VAL_DEF = 0;

    // Pointer width for a given depth; a single-entry FIFO still needs a 1-bit pointer.
    function automatic int unsigned aw_f(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sound_fifo_ram.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port.
module sound_fifo_ram
    import sound_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // Storage write; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sound_cmd_fifo.sv
// Main-CPU to sound-CPU command FIFO with status, sticky overflow and irq.
module sound_cmd_fifo
    import sound_pkg::*;
#(
    parameter int unsigned   DW          = DW_DEF,
    parameter int unsigned   DEPTH       = 4,
    parameter bit            STICKY_LAST = 1'b1,
    parameter logic [DW-1:0] EMPTY_VAL   = DW'(EMPTY_VAL_DEF),
    parameter bit            OVERWRITE   = 1'b0,
    parameter bit            IRQ_EN      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 cs,
    input  logic                 rd,
    output logic [DW-1:0]        rd_data,
    output logic [aw_f(DEPTH):0] level,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow,
    input  logic                 ovf_clr,
    output logic                 irq_n
);

    localparam int unsigned   AW       = aw_f(DEPTH);
    localparam int unsigned   LW       = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [LW-1:0] level_q, level_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic [DW-1:0] last_q, last_d;
    logic          ovf_q, ovf_d;
    logic          irq_n_q, irq_n_d;

    logic          empty_c, full_c;
    logic          do_pop, do_push, ovf_set, do_ovw;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] head;

    // Pointer step mod DEPTH; a single-entry FIFO keeps its pointer at 0.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (DEPTH == 1) ? '0 : p + AW'(1);
    endfunction

    function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
        return (DEPTH == 1) ? '0 : p - AW'(1);
    endfunction

    // Transaction decode; a pop frees the slot so a full push+pop is not an overflow.
    always_comb begin
        empty_c   = (level_q == '0);
        full_c    = (level_q == LVL_FULL);
        do_pop    = cs & rd & ~empty_c;
        do_push   = wr & (~full_c | do_pop);
        ovf_set   = wr & full_c & ~do_pop;
        do_ovw    = ovf_set & OVERWRITE;
        ram_we    = ~reset & (do_push | do_ovw);
        ram_waddr = do_ovw ? ptr_dec(wp_q) : wp_q;
    end

    sound_fifo_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (wr_data),
        .raddr (rp_q),
        .rdata (head)
    );

    // Next-state for pointers, level, read bus, flags and irq.
    always_comb begin
        wp_d      = wp_q;
        rp_d      = rp_q;
        last_d    = last_q;
        rd_data_d = rd_data_q;
        ovf_d     = ovf_q;

        if (do_push) begin
            wp_d = ptr_inc(wp_q);
        end
        if (do_pop) begin
            rp_d   = ptr_inc(rp_q);
            last_d = head;
        end
        level_d = level_q + LW'(do_push) - LW'(do_pop);

        if (!cs) begin
            rd_data_d = '0;
        end else if (rd) begin
            if (do_pop) begin
                rd_data_d = head;
            end else begin
                rd_data_d = STICKY_LAST ? last_q : EMPTY_VAL;
            end
        end

        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        irq_n_d = ~(IRQ_EN && (level_d != '0));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q      <= '0;
            rp_q      <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
            last_q    <= EMPTY_VAL;
            ovf_q     <= 1'b0;
            irq_n_q   <= 1'b1;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
            irq_n_q   <= irq_n_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign level    = level_q;
    assign empty    = empty_c;
    assign full     = full_c;
    assign overflow = ovf_q;
    assign irq_n    = irq_n_q;

endmodule

// File: tb/tb_sound_cmd_fifo.sv
// Bench for sound_cmd_fifo: three configurations share one stimulus stream.
module tb_sound_cmd_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, wr, cs, rd, ovf_clr;
    logic [7:0] wr_data;

    logic [7:0] rd0, rd1, rd2;
    logic [2:0] lv0;
    logic [1:0] lv1, lv2;
    logic       em0, em1, em2, fu0, fu1, fu2, ov0, ov1, ov2, irq0, irq1, irq2;

    int n_checks = 0;
    int n_fail   = 0;

    sound_cmd_fifo #(.DEPTH(4)) u_d4 (
        .clk(clk), .reset(reset), .wr(wr), .wr_data(wr_data), .cs(cs), .rd(rd),
        .rd_data(rd0), .level(lv0), .empty(em0), .full(fu0), .overflow(ov0),
        .ovf_clr(ovf_clr), .irq_n(irq0)
    );

    sound_cmd_fifo #(.DEPTH(2), .OVERWRITE(1'b1)) u_d2 (
        .clk(clk), .reset(reset), .wr(wr), .wr_data(wr_data), .cs(cs), .rd(rd),
        .rd_data(rd1), .level(lv1), .empty(em1), .full(fu1), .overflow(ov1),
        .ovf_clr(ovf_clr), .irq_n(irq1)
    );

    sound_cmd_fifo #(.DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .wr(wr), .wr_data(wr_data), .cs(cs), .rd(rd),
        .rd_data(rd2), .level(lv2), .empty(em2), .full(fu2), .overflow(ov2),
        .ovf_clr(ovf_clr), .irq_n(irq2)
    );

    // Reference model: one queue per configuration.
    logic [7:0] q0[$], q1[$], q2[$];
    logic [7:0] m_rd   [3];
    logic [7:0] m_last [3];
    bit         m_ovf  [3];
    int         depth_of [3] = '{4, 2, 1};
    bit         ow_of    [3] = '{1'b0, 1'b1, 1'b0};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input int k);
        logic [7:0] q[$];
        logic [7:0] h;
        bit         pop, is_full;
        int         a_rd, a_lv, a_em, a_fu, a_ov, a_irq;
        string      tag;
        h = 8'h00;
        case (k)
            0:       q = q0;
            1:       q = q1;
            default: q = q2;
        endcase
        if (reset) begin
            q.delete();
            m_rd[k]   = 8'h00;
            m_last[k] = 8'h00;
            m_ovf[k]  = 1'b0;
        end else begin
            is_full = (q.size() == depth_of[k]);
            pop     = cs && rd && (q.size() != 0);
            if (pop) begin
                h = q.pop_front();
            end
            if (!cs)     m_rd[k] = 8'h00;
            else if (rd) m_rd[k] = pop ? h : m_last[k];
            if (pop) m_last[k] = h;
            if (wr && (!is_full || pop)) begin
                q.push_back(wr_data);
            end
            if (wr && is_full && !pop) begin
                m_ovf[k] = 1'b1;
                if (ow_of[k]) q[q.size()-1] = wr_data;
            end else if (ovf_clr) begin
                m_ovf[k] = 1'b0;
            end
        end
        case (k)
            0: begin q0 = q; a_rd = int'(rd0); a_lv = int'(lv0); a_em = int'(em0);
                     a_fu = int'(fu0); a_ov = int'(ov0); a_irq = int'(irq0); end
            1: begin q1 = q; a_rd = int'(rd1); a_lv = int'(lv1); a_em = int'(em1);
                     a_fu = int'(fu1); a_ov = int'(ov1); a_irq = int'(irq1); end
            default: begin q2 = q; a_rd = int'(rd2); a_lv = int'(lv2); a_em = int'(em2);
                     a_fu = int'(fu2); a_ov = int'(ov2); a_irq = int'(irq2); end
        endcase
        tag = $sformatf("model D%0d", depth_of[k]);
        chk({tag, " rd_data"},  a_rd,  int'(m_rd[k]));
        chk({tag, " level"},    a_lv,  q.size());
        chk({tag, " empty"},    a_em,  int'(q.size() == 0));
        chk({tag, " full"},     a_fu,  int'(q.size() == depth_of[k]));
        chk({tag, " overflow"}, a_ov,  int'(m_ovf[k]));
        chk({tag, " irq_n"},    a_irq, int'(q.size() == 0));
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic cyc(input logic r_st, input logic w, input logic [7:0] d,
                       input logic c, input logic r, input logic oc);
        reset = r_st; wr = w; wr_data = d; cs = c; rd = r; ovf_clr = oc;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) model_step(k);
    endtask

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       c;
        logic       r;
        logic       oc;
        logic [7:0] e_rd;
        int         e_lv;
        logic       e_ovf;
        logic       e_irqn;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [7:0] d, input logic c,
                                input logic r, input logic oc, input logic [7:0] e_rd,
                                input int e_lv, input logic e_ovf, input logic e_irqn);
        vec_t v;
        v.w = w; v.d = d; v.c = c; v.r = r; v.oc = oc;
        v.e_rd = e_rd; v.e_lv = e_lv; v.e_ovf = e_ovf; v.e_irqn = e_irqn;
        return v;
    endfunction

    vec_t tv[$];

    initial begin
        reset = 1'b1; wr = 1'b0; wr_data = 8'h00; cs = 1'b0; rd = 1'b0; ovf_clr = 1'b0;

        // Expected DEPTH=4 behaviour:   w  data  cs rd clr  rd_data lvl ovf irq_n
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 1));
        tv.push_back(mk(1, 8'h12, 1, 0, 0, 8'h00, 1, 0, 0));
        tv.push_back(mk(1, 8'h34, 1, 0, 0, 8'h00, 2, 0, 0));
        tv.push_back(mk(1, 8'h56, 1, 0, 0, 8'h00, 3, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 8'h12, 2, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 8'h34, 1, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 8'h56, 0, 0, 1));
        tv.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
        tv.push_back(mk(1, 8'h01, 0, 0, 0, 8'h00, 1, 0, 0));
        tv.push_back(mk(1, 8'h02, 0, 0, 0, 8'h00, 2, 0, 0));
        tv.push_back(mk(1, 8'h03, 0, 0, 0, 8'h00, 3, 0, 0));
        tv.push_back(mk(1, 8'h04, 0, 0, 0, 8'h00, 4, 0, 0));
        tv.push_back(mk(1, 8'h05, 0, 0, 0, 8'h00, 4, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 8'h01, 3, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 8'h02, 2, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 8'h03, 1, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 8'h04, 0, 1, 1));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 8'h04, 0, 1, 1));
        tv.push_back(mk(0, 8'h00, 1, 0, 1, 8'h04, 0, 0, 1));
        tv.push_back(mk(1, 8'hA1, 1, 0, 0, 8'h04, 1, 0, 0));
        tv.push_back(mk(1, 8'hA2, 1, 0, 0, 8'h04, 2, 0, 0));
        tv.push_back(mk(1, 8'hA3, 1, 0, 0, 8'h04, 3, 0, 0));
        tv.push_back(mk(1, 8'hA4, 1, 0, 0, 8'h04, 4, 0, 0));
        tv.push_back(mk(1, 8'h77, 1, 1, 0, 8'hA1, 4, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 8'hA2, 3, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 8'hA3, 2, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 8'hA4, 1, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 8'h77, 0, 0, 1));
        tv.push_back(mk(1, 8'h99, 1, 1, 0, 8'h77, 1, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 8'h99, 0, 0, 1));
        tv.push_back(mk(1, 8'hB0, 0, 0, 0, 8'h00, 1, 0, 0));
        tv.push_back(mk(1, 8'hB1, 0, 0, 0, 8'h00, 2, 0, 0));
        tv.push_back(mk(1, 8'hB2, 0, 0, 0, 8'h00, 3, 0, 0));
        tv.push_back(mk(1, 8'hB3, 0, 0, 0, 8'h00, 4, 0, 0));
        tv.push_back(mk(1, 8'hB4, 0, 0, 1, 8'h00, 4, 1, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 4, 0, 0));

        // Reset state
        cyc(1, 0, 8'h00, 0, 0, 0);
        cyc(1, 0, 8'h00, 0, 0, 0);
        chk("reset rd_data", int'(rd0), 0);
        chk("reset level",   int'(lv0), 0);
        chk("reset empty",   int'(em0), 1);
        chk("reset irq_n",   int'(irq0), 1);

        // Directed table on the DEPTH=4 instance
        foreach (tv[i]) begin
            cyc(0, tv[i].w, tv[i].d, tv[i].c, tv[i].r, tv[i].oc);
            chk($sformatf("tv[%0d] rd_data", i),  int'(rd0),  int'(tv[i].e_rd));
            chk($sformatf("tv[%0d] level", i),    int'(lv0),  tv[i].e_lv);
            chk($sformatf("tv[%0d] empty", i),    int'(em0),  int'(tv[i].e_lv == 0));
            chk($sformatf("tv[%0d] full", i),     int'(fu0),  int'(tv[i].e_lv == 4));
            chk($sformatf("tv[%0d] overflow", i), int'(ov0),  int'(tv[i].e_ovf));
            chk($sformatf("tv[%0d] irq_n", i),    int'(irq0), int'(tv[i].e_irqn));
        end

        // DEPTH=2 overwrite: newest entry replaced
        cyc(1, 0, 8'h00, 0, 0, 0);
        cyc(0, 1, 8'hA0, 0, 0, 0);
        cyc(0, 1, 8'hA1, 0, 0, 0);
        cyc(0, 1, 8'hA2, 0, 0, 0);
        chk("ovw level", int'(lv1), 2);
        chk("ovw overflow", int'(ov1), 1);
        cyc(0, 0, 8'h00, 1, 1, 0);
        chk("ovw pop1", int'(rd1), 8'hA0);
        cyc(0, 0, 8'h00, 1, 1, 0);
        chk("ovw pop2", int'(rd1), 8'hA2);
        chk("ovw drained irq_n", int'(irq1), 1);
        cyc(0, 0, 8'h00, 1, 0, 1);
        chk("ovw cleared", int'(ov1), 0);

        // DEPTH=1 classic latch: sticky re-read, cs drop, mid-operation reset
        cyc(1, 0, 8'h00, 0, 0, 0);
        cyc(0, 1, 8'h12, 0, 0, 0);
        chk("latch level", int'(lv2), 1);
        chk("latch irq_n", int'(irq2), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 8'h00, 1, 1, 0);
            chk($sformatf("latch read %0d", i), int'(rd2), 8'h12);
        end
        cyc(0, 0, 8'h00, 0, 0, 0);
        chk("latch cs drop", int'(rd2), 0);
        cyc(0, 1, 8'h34, 0, 0, 0);
        chk("latch refill level", int'(lv2), 1);
        cyc(1, 1, 8'h56, 1, 1, 0);
        chk("latch reset level", int'(lv2), 0);
        chk("latch reset irq_n", int'(irq2), 1);
        chk("latch reset rd_data", int'(rd2), 0);

        // Random traffic against the model on all three instances
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 299) == 0),
                1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)),
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
